// File: rtl/mpu_ctrl_if.sv
// Host/datapath signal bundle for the MPU sequencing controller.
// The host side drives instructions and stream handshakes; the controller drives everything else.
interface mpu_ctrl_if #(
   parameter int NUM_BANKS = 4,
   parameter int DATA_W    = 512
);
   localparam int SW = $clog2(NUM_BANKS);
   localparam int OW = $clog2(DATA_W);

   logic [4+2*SW-1:0]    instr;
   logic                 instr_valid;
   logic                 instr_ready;
   logic                 busy;
   logic                 done;
   logic                 err;
   logic [SW-1:0]        aa_sel;
   logic [SW-1:0]        dd_sel;
   logic [1:0]           out_sel;
   logic                 bram_in_sel;
   logic [NUM_BANKS-1:0] bank_we;
   logic [NUM_BANKS-1:0] bank_we_byte;
   logic [NUM_BANKS-1:0] bank_rst;
   logic [OW-1:0]        offset;
   logic                 host_in_valid;
   logic                 host_in_ready;
   logic                 host_out_valid;
   logic                 host_out_ready;

   modport master (
      output instr, instr_valid, host_in_valid, host_out_ready,
      input  instr_ready, busy, done, err, aa_sel, dd_sel, out_sel, bram_in_sel,
             bank_we, bank_we_byte, bank_rst, offset, host_in_ready, host_out_valid
   );

   modport slave (
      input  instr, instr_valid, host_in_valid, host_out_ready,
      output instr_ready, busy, done, err, aa_sel, dd_sel, out_sel, bram_in_sel,
             bank_we, bank_we_byte, bank_rst, offset, host_in_ready, host_out_valid
   );
endinterface

// File: rtl/mpu_ctrl.sv
// MPU sequencing controller: accepts one instruction at a time and decodes it into
// bank write/reset enables, operand/result selects and the byte-offset pointer.
module mpu_ctrl #(
   parameter int NUM_BANKS  = 4,
   parameter int DATA_W     = 512,
   parameter int BYTE_W     = 8,
   parameter int OP_LATENCY = 1
) (
   input  logic      clk,
   input  logic      reset,
   mpu_ctrl_if.slave bus
);
   localparam int SW    = $clog2(NUM_BANKS);
   localparam int OW    = $clog2(DATA_W);
   localparam int BEATS = DATA_W / BYTE_W;
   localparam int CW    = $clog2(BEATS + OP_LATENCY + 1);

   localparam logic [OW-1:0] OFFSET_INIT = OW'(BYTE_W - 1);
   localparam logic [OW-1:0] OFFSET_STEP = OW'(BYTE_W);
   localparam logic [CW-1:0] LAST_BEAT   = CW'(BEATS - 1);
   localparam logic [CW-1:0] LAST_WAIT   = CW'(OP_LATENCY - 1);

   typedef enum logic [2:0] {
      S_RESET, S_IDLE, S_EXEC, S_LOAD, S_UNLOAD, S_COPY, S_CLEAR
   } state_t;

   state_t               state_q, state_d;
   logic [1:0]           alu_q, alu_d;
   logic [SW-1:0]        aa_q, aa_d;
   logic [SW-1:0]        dd_q, dd_d;
   logic                 err_q, err_d;
   logic                 nop_done_q, nop_done_d;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic [OW-1:0]        offset_q, offset_d;

   logic [3:0]           opcode;
   logic [SW-1:0]        src;
   logic [SW-1:0]        dst;
   logic                 last_beat;
   logic [NUM_BANKS-1:0] dd_hot;

   assign opcode    = bus.instr[3:0];
   assign src       = bus.instr[SW+3:4];
   assign dst       = bus.instr[2*SW+3:SW+4];
   assign last_beat = (cnt_q == LAST_BEAT);

   generate
      for (genvar gi = 0; gi < NUM_BANKS; gi++) begin : g_dd_hot
         assign dd_hot[gi] = (dd_q == SW'(gi));
      end
   endgenerate

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= S_RESET;
         alu_q      <= 2'b00;
         aa_q       <= '0;
         dd_q       <= '0;
         err_q      <= 1'b0;
         nop_done_q <= 1'b0;
         cnt_q      <= '0;
         offset_q   <= OFFSET_INIT;
      end else begin
         state_q    <= state_d;
         alu_q      <= alu_d;
         aa_q       <= aa_d;
         dd_q       <= dd_d;
         err_q      <= err_d;
         nop_done_q <= nop_done_d;
         cnt_q      <= cnt_d;
         offset_q   <= offset_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      alu_d      = alu_q;
      aa_d       = aa_q;
      dd_d       = dd_q;
      err_d      = err_q;
      nop_done_d = 1'b0;
      cnt_d      = cnt_q;
      offset_d   = offset_q;
      case (state_q)
         S_RESET: state_d = S_IDLE;
         S_IDLE: begin
            cnt_d    = '0;
            offset_d = OFFSET_INIT;
            if (bus.instr_valid) begin
               alu_d = opcode[1:0];
               aa_d  = src;
               dd_d  = dst;
               // A self-copy is flagged here so err is already visible in the COPY cycle.
               err_d = (opcode == 4'b0101) && (src == dst);
               casez (opcode)
                  4'b0100: state_d = S_LOAD;
                  4'b0101: state_d = S_COPY;
                  4'b0110: state_d = S_UNLOAD;
                  4'b0111: state_d = S_CLEAR;
                  4'b11??: state_d = S_EXEC;
                  default: nop_done_d = 1'b1;
               endcase
            end
         end
         S_EXEC: begin
            if (cnt_q == LAST_WAIT) begin
               state_d = S_IDLE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_LOAD, S_UNLOAD: begin
            if ((state_q == S_LOAD) ? bus.host_in_valid : bus.host_out_ready) begin
               if (last_beat) begin
                  state_d  = S_IDLE;
                  cnt_d    = '0;
                  offset_d = OFFSET_INIT;
               end else begin
                  cnt_d    = cnt_q + 1'b1;
                  offset_d = offset_q + OFFSET_STEP;
               end
            end
         end
         S_COPY, S_CLEAR: state_d = S_IDLE;
         default: state_d = S_RESET;
      endcase
   end

   always_comb begin
      bus.instr_ready    = 1'b0;
      bus.busy           = 1'b1;
      bus.done           = nop_done_q;
      bus.out_sel        = 2'b00;
      bus.bram_in_sel    = 1'b0;
      bus.bank_we        = '0;
      bus.bank_we_byte   = '0;
      bus.bank_rst       = '0;
      bus.host_in_ready  = 1'b0;
      bus.host_out_valid = 1'b0;
      case (state_q)
         S_RESET: bus.bank_rst = '1;
         S_IDLE: begin
            bus.instr_ready = 1'b1;
            bus.busy        = 1'b0;
         end
         S_EXEC: begin
            bus.out_sel = alu_q;
            if (cnt_q == LAST_WAIT) begin
               bus.bank_we = dd_hot;
               bus.done    = 1'b1;
            end
         end
         S_LOAD: begin
            bus.host_in_ready = 1'b1;
            if (bus.host_in_valid) begin
               bus.bank_we_byte = dd_hot;
               bus.done         = last_beat;
            end
         end
         S_UNLOAD: begin
            bus.host_out_valid = 1'b1;
            bus.done           = bus.host_out_ready && last_beat;
         end
         S_COPY: begin
            bus.done = 1'b1;
            if (aa_q != dd_q) begin
               bus.bram_in_sel = 1'b1;
               bus.bank_we     = dd_hot;
            end
         end
         S_CLEAR: begin
            bus.done     = 1'b1;
            bus.bank_rst = dd_hot;
         end
         default: ;
      endcase
   end

   assign bus.err    = err_q;
   assign bus.aa_sel = aa_q;
   assign bus.dd_sel = dd_q;
   assign bus.offset = offset_q;
endmodule

// File: tb/tb_mpu_ctrl.sv
// Directed bench for mpu_ctrl: a 4-bank/512-bit instance with 3-cycle ALU latency
// and an 8-bank/256-bit instance with 1-cycle latency, driven on the falling edge.
module tb_mpu_ctrl;
   logic clk   = 1'b0;
   logic reset = 1'b1;
   int   n_run = 0;
   int   n_fail = 0;

   always #5 clk = ~clk;

   mpu_ctrl_if #(.NUM_BANKS(4), .DATA_W(512)) bus4 ();
   mpu_ctrl_if #(.NUM_BANKS(8), .DATA_W(256)) bus8 ();

   mpu_ctrl #(.NUM_BANKS(4), .DATA_W(512), .BYTE_W(8), .OP_LATENCY(3)) u_dut4 (
      .clk(clk), .reset(reset), .bus(bus4)
   );
   mpu_ctrl #(.NUM_BANKS(8), .DATA_W(256), .BYTE_W(8), .OP_LATENCY(1)) u_dut8 (
      .clk(clk), .reset(reset), .bus(bus8)
   );

   task automatic test_reset();
      bus4.instr = '0; bus4.instr_valid = 1'b0; bus4.host_in_valid = 1'b0; bus4.host_out_ready = 1'b0;
      bus8.instr = '0; bus8.instr_valid = 1'b0; bus8.host_in_valid = 1'b0; bus8.host_out_ready = 1'b0;
      reset = 1'b1;
      @(negedge clk); @(negedge clk);
      #1;
      n_run++;
      if ({bus4.busy, bus4.instr_ready, bus4.done, bus4.err, bus4.bram_in_sel, bus4.host_in_ready, bus4.host_out_valid} !== 7'b1000000) begin
         n_fail++; $display("FAIL reset_flags: got %b expected 1000000", {bus4.busy, bus4.instr_ready, bus4.done, bus4.err, bus4.bram_in_sel, bus4.host_in_ready, bus4.host_out_valid});
      end
      n_run++;
      if ({bus4.offset, bus4.out_sel, bus4.aa_sel, bus4.dd_sel} !== {9'd7, 2'd0, 2'd0, 2'd0}) begin
         n_fail++; $display("FAIL reset_fields: got off=%0d sel=%0d aa=%0d dd=%0d expected 7 0 0 0", bus4.offset, bus4.out_sel, bus4.aa_sel, bus4.dd_sel);
      end
      n_run++;
      if ({bus4.bank_we, bus4.bank_we_byte, bus4.bank_rst} !== 12'b0000_0000_1111) begin
         n_fail++; $display("FAIL reset_banks: got we=%b web=%b rst=%b expected 0000 0000 1111", bus4.bank_we, bus4.bank_we_byte, bus4.bank_rst);
      end
      reset = 1'b0;
      #1;
      n_run++;
      if (bus4.bank_rst !== 4'b1111 || bus4.busy !== 1'b1 || bus8.bank_rst !== 8'hFF) begin
         n_fail++; $display("FAIL release_cycle0: got rst4=%b busy=%b rst8=%b expected 1111 1 11111111", bus4.bank_rst, bus4.busy, bus8.bank_rst);
      end
      @(negedge clk); #1;
      n_run++;
      if ({bus4.instr_ready, bus4.busy, bus4.offset, bus4.bank_rst} !== {1'b1, 1'b0, 9'd7, 4'b0000}) begin
         n_fail++; $display("FAIL release_cycle1: got rdy=%b busy=%b off=%0d rst=%b expected 1 0 7 0000", bus4.instr_ready, bus4.busy, bus4.offset, bus4.bank_rst);
      end
      n_run++;
      if (bus8.instr_ready !== 1'b1 || bus8.bank_rst !== 8'h00) begin
         n_fail++; $display("FAIL release_cycle1_b8: got rdy=%b rst=%b expected 1 00000000", bus8.instr_ready, bus8.bank_rst);
      end
   endtask

   task automatic test_nop();
      @(negedge clk);
      bus4.instr = {2'd3, 2'd2, 4'b0010}; bus4.instr_valid = 1'b1;
      @(negedge clk);
      bus4.instr_valid = 1'b0; bus4.instr = '0;
      #1;
      n_run++;
      if ({bus4.done, bus4.busy, bus4.instr_ready, bus4.bank_we, bus4.bank_rst} !== {3'b101, 8'h00}) begin
         n_fail++; $display("FAIL nop_done: got done=%b busy=%b rdy=%b we=%b rst=%b expected 1 0 1 0000 0000", bus4.done, bus4.busy, bus4.instr_ready, bus4.bank_we, bus4.bank_rst);
      end
      n_run++;
      if (bus4.aa_sel !== 2'd2 || bus4.dd_sel !== 2'd3) begin
         n_fail++; $display("FAIL nop_latch: got aa=%0d dd=%0d expected 2 3", bus4.aa_sel, bus4.dd_sel);
      end
      @(negedge clk); #1;
      n_run++;
      if (bus4.done !== 1'b0) begin
         n_fail++; $display("FAIL nop_pulse: got done=%b expected 0", bus4.done);
      end
   endtask

   task automatic test_exec();
      logic [3:0] ops  [3] = '{4'b1100, 4'b1110, 4'b1101};
      logic [1:0] aas  [3] = '{2'd1, 2'd3, 2'd0};
      logic [1:0] dds  [3] = '{2'd2, 2'd0, 2'd3};
      logic [1:0] sels [3] = '{2'd0, 2'd2, 2'd1};
      logic [3:0] we;
      logic [7:0] exp_v;
      for (int t = 0; t < 3; t++) begin
         @(negedge clk);
         bus4.instr = {dds[t], aas[t], ops[t]}; bus4.instr_valid = 1'b1;
         #1;
         n_run++;
         if (bus4.instr_ready !== 1'b1) begin
            n_fail++; $display("FAIL exec_ready t=%0d: got %b expected 1", t, bus4.instr_ready);
         end
         @(negedge clk);
         bus4.instr_valid = 1'b0; bus4.instr = 8'hFF;
         for (int k = 1; k <= 3; k++) begin
            #1;
            we    = (k == 3) ? (4'b0001 << dds[t]) : 4'b0000;
            exp_v = {1'b1, 1'(k == 3), sels[t], we};
            n_run++;
            if ({bus4.busy, bus4.done, bus4.out_sel, bus4.bank_we} !== exp_v) begin
               n_fail++; $display("FAIL exec t=%0d k=%0d: got busy/done/sel/we=%b expected %b", t, k, {bus4.busy, bus4.done, bus4.out_sel, bus4.bank_we}, exp_v);
            end
            if (k == 1) begin
               n_run++;
               if (bus4.aa_sel !== aas[t] || bus4.dd_sel !== dds[t]) begin
                  n_fail++; $display("FAIL exec_fields t=%0d: got aa=%0d dd=%0d expected %0d %0d", t, bus4.aa_sel, bus4.dd_sel, aas[t], dds[t]);
               end
            end
            @(negedge clk);
         end
         bus4.instr = '0;
         #1;
         n_run++;
         if ({bus4.instr_ready, bus4.done, bus4.out_sel} !== 4'b1000) begin
            n_fail++; $display("FAIL exec_after t=%0d: got rdy/done/sel=%b expected 1000", t, {bus4.instr_ready, bus4.done, bus4.out_sel});
         end
      end
   endtask

   task automatic test_exec8();
      @(negedge clk);
      bus8.instr = {3'd6, 3'd3, 4'b1111}; bus8.instr_valid = 1'b1;
      @(negedge clk);
      bus8.instr_valid = 1'b0; bus8.instr = '0;
      #1;
      n_run++;
      if ({bus8.busy, bus8.done, bus8.out_sel, bus8.bank_we} !== {2'b11, 2'd3, 8'h40}) begin
         n_fail++; $display("FAIL exec8: got busy/done/sel/we=%b expected 111101000000", {bus8.busy, bus8.done, bus8.out_sel, bus8.bank_we});
      end
      @(negedge clk); #1;
      n_run++;
      if ({bus8.instr_ready, bus8.done, bus8.out_sel, bus8.bank_we} !== {2'b10, 2'd0, 8'h00}) begin
         n_fail++; $display("FAIL exec8_after: got %b expected 100000000000", {bus8.instr_ready, bus8.done, bus8.out_sel, bus8.bank_we});
      end
   endtask

   task automatic test_copy_err();
      @(negedge clk);
      bus4.instr = {2'd1, 2'd1, 4'b0101}; bus4.instr_valid = 1'b1;
      @(negedge clk);
      bus4.instr_valid = 1'b0;
      #1;
      n_run++;
      if ({bus4.err, bus4.done, bus4.bram_in_sel, bus4.bank_we} !== 7'b1100000) begin
         n_fail++; $display("FAIL copy_self: got err/done/bsel/we=%b expected 1100000", {bus4.err, bus4.done, bus4.bram_in_sel, bus4.bank_we});
      end
      @(negedge clk);
      bus4.instr = {2'd0, 2'd0, 4'b0111}; bus4.instr_valid = 1'b1;
      #1;
      n_run++;
      if (bus4.err !== 1'b1 || bus4.instr_ready !== 1'b1) begin
         n_fail++; $display("FAIL err_sticky: got err=%b rdy=%b expected 1 1", bus4.err, bus4.instr_ready);
      end
      @(negedge clk);
      bus4.instr_valid = 1'b0;
      #1;
      n_run++;
      if ({bus4.err, bus4.done, bus4.bank_rst, bus4.bank_we} !== 10'b01_0001_0000) begin
         n_fail++; $display("FAIL clear_bank0: got err/done/rst/we=%b expected 0100010000", {bus4.err, bus4.done, bus4.bank_rst, bus4.bank_we});
      end
      @(negedge clk);
      bus4.instr = {2'd3, 2'd2, 4'b0101}; bus4.instr_valid = 1'b1;
      @(negedge clk);
      bus4.instr_valid = 1'b0;
      #1;
      n_run++;
      if ({bus4.err, bus4.done, bus4.bram_in_sel, bus4.bank_we, bus4.aa_sel} !== 9'b011_1000_10) begin
         n_fail++; $display("FAIL copy_ok: got err/done/bsel/we/aa=%b expected 011100010", {bus4.err, bus4.done, bus4.bram_in_sel, bus4.bank_we, bus4.aa_sel});
      end
   endtask

   task automatic test_back_to_back();
      logic exp_done;
      @(negedge clk);
      bus4.instr = {2'd2, 2'd0, 4'b0111}; bus4.instr_valid = 1'b1;
      #1;
      n_run++;
      if (bus4.instr_ready !== 1'b1) begin
         n_fail++; $display("FAIL b2b_ready0: got %b expected 1", bus4.instr_ready);
      end
      for (int k = 1; k <= 4; k++) begin
         @(negedge clk);
         if (k == 3) bus4.instr_valid = 1'b0;
         #1;
         exp_done = (k == 1) || (k == 3);
         n_run++;
         if ({bus4.done, bus4.instr_ready, bus4.bank_rst} !== {exp_done, ~exp_done, (exp_done ? 4'b0100 : 4'b0000)}) begin
            n_fail++; $display("FAIL b2b k=%0d: got done/rdy/rst=%b expected %b", k, {bus4.done, bus4.instr_ready, bus4.bank_rst}, {exp_done, ~exp_done, (exp_done ? 4'b0100 : 4'b0000)});
         end
      end
   endtask

   task automatic test_load();
      int   b = 0;
      int   c = 0;
      logic v;
      logic exp_done;
      @(negedge clk);
      bus4.instr = {2'd3, 2'd0, 4'b0100}; bus4.instr_valid = 1'b1;
      @(negedge clk);
      bus4.instr_valid = 1'b0; bus4.instr = 8'hC7;
      while (b < 64 && c < 200) begin
         v = !(c >= 10 && c <= 12);
         bus4.host_in_valid = v;
         #1;
         exp_done = v && (b == 63);
         n_run++;
         if (bus4.bank_we_byte !== (v ? 4'b1000 : 4'b0000)) begin
            n_fail++; $display("FAIL load_we c=%0d: got %b expected %b", c, bus4.bank_we_byte, (v ? 4'b1000 : 4'b0000));
         end
         n_run++;
         if (bus4.offset !== 9'(7 + 8 * b)) begin
            n_fail++; $display("FAIL load_offset c=%0d: got %0d expected %0d", c, bus4.offset, 7 + 8 * b);
         end
         n_run++;
         if (bus4.done !== exp_done || bus4.host_in_ready !== 1'b1 || bus4.busy !== 1'b1) begin
            n_fail++; $display("FAIL load_ctl c=%0d: got done=%b rdy=%b busy=%b expected %b 1 1", c, bus4.done, bus4.host_in_ready, bus4.busy, exp_done);
         end
         if (v) b++;
         c++;
         @(negedge clk);
      end
      bus4.host_in_valid = 1'b0;
      #1;
      n_run++;
      if ({bus4.instr_ready, bus4.done, bus4.host_in_ready, bus4.offset} !== {3'b100, 9'd7}) begin
         n_fail++; $display("FAIL load_after: got rdy=%b done=%b hrdy=%b off=%0d expected 1 0 0 7", bus4.instr_ready, bus4.done, bus4.host_in_ready, bus4.offset);
      end
   endtask

   task automatic test_reset_mid_load();
      @(negedge clk);
      bus4.instr = {2'd1, 2'd0, 4'b0100}; bus4.instr_valid = 1'b1;
      @(negedge clk);
      bus4.instr_valid = 1'b0;
      bus4.host_in_valid = 1'b1;
      for (int c = 0; c < 19; c++) @(negedge clk);
      #1;
      n_run++;
      if (bus4.bank_we_byte !== 4'b0010 || bus4.offset !== 9'd159 || bus4.done !== 1'b0) begin
         n_fail++; $display("FAIL midload_beat20: got web=%b off=%0d done=%b expected 0010 159 0", bus4.bank_we_byte, bus4.offset, bus4.done);
      end
      #1 reset = 1'b1;
      #1;
      n_run++;
      if ({bus4.busy, bus4.instr_ready, bus4.done, bus4.host_in_ready, bus4.bank_we_byte, bus4.bank_rst, bus4.offset} !== {4'b1000, 4'b0000, 4'b1111, 9'd7}) begin
         n_fail++; $display("FAIL midload_async: got busy=%b rdy=%b done=%b hrdy=%b web=%b rst=%b off=%0d expected 1 0 0 0 0000 1111 7", bus4.busy, bus4.instr_ready, bus4.done, bus4.host_in_ready, bus4.bank_we_byte, bus4.bank_rst, bus4.offset);
      end
      @(negedge clk); #1;
      n_run++;
      if (bus4.done !== 1'b0 || bus4.bank_rst !== 4'b1111) begin
         n_fail++; $display("FAIL midload_held: got done=%b rst=%b expected 0 1111", bus4.done, bus4.bank_rst);
      end
      @(negedge clk);
      bus4.host_in_valid = 1'b0;
      reset = 1'b0;
      #1;
      n_run++;
      if (bus4.bank_rst !== 4'b1111 || bus4.busy !== 1'b1 || bus4.done !== 1'b0) begin
         n_fail++; $display("FAIL midload_restart0: got rst=%b busy=%b done=%b expected 1111 1 0", bus4.bank_rst, bus4.busy, bus4.done);
      end
      @(negedge clk); #1;
      n_run++;
      if ({bus4.instr_ready, bus4.busy, bus4.done, bus4.offset} !== {3'b100, 9'd7}) begin
         n_fail++; $display("FAIL midload_restart1: got rdy=%b busy=%b done=%b off=%0d expected 1 0 0 7", bus4.instr_ready, bus4.busy, bus4.done, bus4.offset);
      end
   endtask

   task automatic test_unload8();
      int   b = 0;
      int   c = 0;
      logic r;
      logic exp_done;
      @(negedge clk);
      bus8.instr = {3'd5, 3'd0, 4'b0110}; bus8.instr_valid = 1'b1;
      @(negedge clk);
      bus8.instr_valid = 1'b0; bus8.instr = '0;
      while (b < 32 && c < 200) begin
         r = (c % 2) == 1;
         bus8.host_out_ready = r;
         #1;
         exp_done = r && (b == 31);
         n_run++;
         if (bus8.offset !== 8'(7 + 8 * b)) begin
            n_fail++; $display("FAIL unload_offset c=%0d: got %0d expected %0d", c, bus8.offset, 7 + 8 * b);
         end
         n_run++;
         if (bus8.done !== exp_done || bus8.host_out_valid !== 1'b1 || bus8.dd_sel !== 3'd5) begin
            n_fail++; $display("FAIL unload_ctl c=%0d: got done=%b oval=%b dd=%0d expected %b 1 5", c, bus8.done, bus8.host_out_valid, bus8.dd_sel, exp_done);
         end
         n_run++;
         if (bus8.bank_we !== 8'h00 || bus8.bank_we_byte !== 8'h00) begin
            n_fail++; $display("FAIL unload_nowrite c=%0d: got we=%b web=%b expected 0 0", c, bus8.bank_we, bus8.bank_we_byte);
         end
         if (r) b++;
         c++;
         @(negedge clk);
      end
      bus8.host_out_ready = 1'b0;
      #1;
      n_run++;
      if ({bus8.instr_ready, bus8.busy, bus8.done, bus8.host_out_valid} !== 4'b1000) begin
         n_fail++; $display("FAIL unload_after: got rdy/busy/done/oval=%b expected 1000", {bus8.instr_ready, bus8.busy, bus8.done, bus8.host_out_valid});
      end
   endtask

   initial begin
      test_reset();
      test_nop();
      test_exec();
      test_exec8();
      test_copy_err();
      test_back_to_back();
      test_load();
      test_reset_mid_load();
      test_unload8();
      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end
endmodule
